// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared types and constants for the writeback port arbiter.
//               It holds the exception record, the scoreboard tag width, the
//               default writeback entry, and a helper that sizes index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int XLEN          = 64;
    localparam int TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    // Writeback entry at the default widths. The top level builds its own
    // entry type from its DATA_WIDTH / TRANS_ID_W parameters.
    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } wb_entry_t;

    // Width of an index into n items. It is never zero, so a 1-item index
    // still gets a legal 1-bit vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Producer and writeback bundle of the writeback port arbiter.
//               master : functional-unit side / environment
//               slave  : the arbiter
//   flush_i        1                   flush all buffered results
//   fu_valid_i     NR_FU               channel result valid
//   fu_ready_o     NR_FU               channel can accept a result
//   fu_result_i    NR_FU x DATA_WIDTH  result data
//   fu_trans_id_i  NR_FU x TRANS_ID_W  scoreboard tag
//   fu_ex_i        NR_FU x exception_t exception info
//   wb_valid_o     NR_WB_PORTS         write-port valid
//   wb_result_o    NR_WB_PORTS x DATA_WIDTH
//   wb_trans_id_o  NR_WB_PORTS x TRANS_ID_W
//   wb_ex_o        NR_WB_PORTS x exception_t
//   wb_src_o       NR_WB_PORTS x clog2(NR_FU)  granted channel index
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if import wb_port_arbiter_pkg::*; #(
    parameter int NR_FU       = 4,
    parameter int NR_WB_PORTS = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int TRANS_ID_W  = TRANS_ID_BITS
) ();

    localparam int SRC_W = idx_width(NR_FU);

    logic                                    flush_i;
    logic [NR_FU-1:0]                        fu_valid_i;
    logic [NR_FU-1:0]                        fu_ready_o;
    logic [NR_FU-1:0][DATA_WIDTH-1:0]        fu_result_i;
    logic [NR_FU-1:0][TRANS_ID_W-1:0]        fu_trans_id_i;
    exception_t [NR_FU-1:0]                  fu_ex_i;

    logic [NR_WB_PORTS-1:0]                  wb_valid_o;
    logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]  wb_result_o;
    logic [NR_WB_PORTS-1:0][TRANS_ID_W-1:0]  wb_trans_id_o;
    exception_t [NR_WB_PORTS-1:0]            wb_ex_o;
    logic [NR_WB_PORTS-1:0][SRC_W-1:0]       wb_src_o;

    modport master (
        output flush_i, fu_valid_i, fu_result_i, fu_trans_id_i, fu_ex_i,
        input  fu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_o, wb_src_o
    );

    modport slave (
        input  flush_i, fu_valid_i, fu_result_i, fu_trans_id_i, fu_ex_i,
        output fu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_o, wb_src_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_fifo
// Description : Single-channel result FIFO, generic in entry type.
//   clk, rst (async, active-high)
//   i_flush  synchronous clear; overrides push and pop
//   i_push   write i_data (ignored while full)
//   i_pop    drop the head entry (ignored while empty)
//   o_full, o_empty  from registered occupancy only
//   o_head   current head entry (undefined while empty)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_flush,
    input  wire logic i_push,
    input  wire T     i_data,
    input  wire logic i_pop,
    output logic      o_full,
    output logic      o_empty,
    output T          o_head
);

    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    T                 r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A full FIFO refuses a push even while it is popped in the same cycle,
    // so that ready depends only on registered state.
    assign w_push = i_push && !o_full  && !i_flush;
    assign w_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The storage has no reset. Whether an entry is live is set by the
    // pointers and the count alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        (i_push && !i_flush) |-> !o_full);
`endif

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Merges NR_FU functional-unit result channels onto NR_WB_PORTS
//               scoreboard write ports. Each channel buffers results in its
//               own FIFO. A round-robin scan starting at r_rr grants the first
//               NR_WB_PORTS non-empty channels, in scan order, to ports 0,1,..
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    wb_port_arbiter_if.slave (producer inputs, writeback outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter import wb_port_arbiter_pkg::*; #(
    parameter int NR_FU       = 4,
    parameter int NR_WB_PORTS = 2,
    parameter int DEPTH       = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int TRANS_ID_W  = TRANS_ID_BITS
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    wb_port_arbiter_if.slave bus
);

    localparam int                  SRC_W      = idx_width(NR_FU);
    localparam int                  PORT_CNT_W = $clog2(NR_WB_PORTS + 1);
    localparam logic [SRC_W:0]      c_NR_FU    = (SRC_W + 1)'(NR_FU);
    localparam logic [PORT_CNT_W-1:0] c_NR_PORTS = PORT_CNT_W'(NR_WB_PORTS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [TRANS_ID_W-1:0] trans_id;
        exception_t            ex;
    } entry_t;

    logic [SRC_W-1:0]                  r_rr;

    logic [NR_FU-1:0]                  w_full;
    logic [NR_FU-1:0]                  w_empty;
    logic [NR_FU-1:0]                  w_ready;
    logic [NR_FU-1:0]                  w_grant;
    entry_t                            w_head [NR_FU];

    logic                              w_any_grant;
    logic [SRC_W-1:0]                  w_rr_next;
    logic [NR_WB_PORTS-1:0]            w_wb_valid;
    entry_t                            w_wb_entry [NR_WB_PORTS];
    logic [NR_WB_PORTS-1:0][SRC_W-1:0] w_wb_src;

    assign w_ready        = ~w_full;
    assign bus.fu_ready_o = w_ready;

    // ------------------------------------------------------------------
    // Per-channel result buffers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NR_FU; i++) begin : g_fifo
        entry_t w_in;
        assign w_in = '{result:   bus.fu_result_i[i],
                        trans_id: bus.fu_trans_id_i[i],
                        ex:       bus.fu_ex_i[i]};

        wb_port_arbiter_fifo #(
            .DEPTH (DEPTH),
            .T     (entry_t)
        ) u_fifo (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_flush (bus.flush_i),
            .i_push  (bus.fu_valid_i[i] & w_ready[i]),
            .i_data  (w_in),
            .i_pop   (w_grant[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i]),
            .o_head  (w_head[i])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin scan. v_n counts the ports handed out so far. The port
    // loop maps that count onto a constant port index, so no port is ever
    // addressed by a variable index.
    // ------------------------------------------------------------------
    always_comb begin
        logic [SRC_W:0]        v_sum;
        logic [SRC_W-1:0]      v_idx;
        logic [PORT_CNT_W-1:0] v_n;

        w_grant     = '0;
        w_any_grant = 1'b0;
        w_rr_next   = r_rr;
        w_wb_valid  = '0;
        w_wb_src    = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) w_wb_entry[p] = '0;
        v_sum = '0;
        v_idx = '0;
        v_n   = '0;

        for (int k = 0; k < NR_FU; k++) begin
            v_sum = {1'b0, r_rr} + (SRC_W + 1)'(k);
            if (v_sum >= c_NR_FU) v_sum = v_sum - c_NR_FU;
            v_idx = v_sum[SRC_W-1:0];

            if (!w_empty[v_idx] && (v_n < c_NR_PORTS)) begin
                w_grant[v_idx] = 1'b1;
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (v_n == PORT_CNT_W'(p)) begin
                        w_wb_valid[p] = 1'b1;
                        w_wb_entry[p] = w_head[v_idx];
                        w_wb_src[p]   = v_idx;
                    end
                end
                // The last grant in scan order decides where the next scan
                // starts.
                v_sum       = {1'b0, v_idx} + 1'b1;
                w_rr_next   = (v_sum == c_NR_FU) ? '0 : v_sum[SRC_W-1:0];
                w_any_grant = 1'b1;
                v_n         = v_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (bus.flush_i) begin
            r_rr <= '0;
        end else if (w_any_grant) begin
            r_rr <= w_rr_next;
        end
    end

    // ------------------------------------------------------------------
    // Write-port outputs. Ports with no grant carry a zero payload.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_port
        assign bus.wb_valid_o[p]    = w_wb_valid[p];
        assign bus.wb_result_o[p]   = w_wb_entry[p].result;
        assign bus.wb_trans_id_o[p] = w_wb_entry[p].trans_id;
        assign bus.wb_ex_o[p]       = w_wb_entry[p].ex;
        assign bus.wb_src_o[p]      = w_wb_src[p];
    end

`ifndef SYNTHESIS
    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_chk_a
        for (genvar q = p + 1; q < NR_WB_PORTS; q++) begin : g_chk_b
            a_src_unique: assert property (@(posedge clk_i) disable iff (rst_i)
                !(w_wb_valid[p] && w_wb_valid[q] && (w_wb_src[p] == w_wb_src[q])));
            a_tag_unique: assert property (@(posedge clk_i) disable iff (rst_i)
                !(w_wb_valid[p] && w_wb_valid[q] &&
                  (w_wb_entry[p].trans_id == w_wb_entry[q].trans_id)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench. Instance u_dut2 uses 4 channels
//               and 2 write ports. Instance u_dut1 uses 4 channels and 1
//               write port, and is used for the alternation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int NFU = 4;
    localparam int TW  = 8;
    localparam int DW  = 64;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    wb_port_arbiter_if #(.NR_FU(NFU), .NR_WB_PORTS(2), .DATA_WIDTH(DW), .TRANS_ID_W(TW)) bus2 ();
    wb_port_arbiter_if #(.NR_FU(NFU), .NR_WB_PORTS(1), .DATA_WIDTH(DW), .TRANS_ID_W(TW)) bus1 ();

    wb_port_arbiter #(
        .NR_FU(NFU), .NR_WB_PORTS(2), .DEPTH(2), .DATA_WIDTH(DW), .TRANS_ID_W(TW)
    ) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    wb_port_arbiter #(
        .NR_FU(NFU), .NR_WB_PORTS(1), .DEPTH(2), .DATA_WIDTH(DW), .TRANS_ID_W(TW)
    ) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle2();
        bus2.flush_i       = 1'b0;
        bus2.fu_valid_i    = '0;
        bus2.fu_result_i   = '0;
        bus2.fu_trans_id_i = '0;
        bus2.fu_ex_i       = '0;
    endtask

    task automatic idle1();
        bus1.flush_i       = 1'b0;
        bus1.fu_valid_i    = '0;
        bus1.fu_result_i   = '0;
        bus1.fu_trans_id_i = '0;
        bus1.fu_ex_i       = '0;
    endtask

    task automatic drive2(input int ch, input logic [63:0] res, input logic [7:0] tag);
        bus2.fu_valid_i[ch]    = 1'b1;
        bus2.fu_result_i[ch]   = res;
        bus2.fu_trans_id_i[ch] = tag;
    endtask

    initial begin
        rst = 1'b0;
        idle2();
        idle1();
        #1 rst = 1'b1;
        #1;
        check("rst_valid",  bus2.wb_valid_o, 2'b00);
        check("rst_ready",  bus2.fu_ready_o, 4'hF);
        check("rst_src",    bus2.wb_src_o, 0);
        check("rst_result", bus2.wb_result_o[0], 0);
        check("rst_tag",    bus2.wb_trans_id_o[0], 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_valid", bus2.wb_valid_o, 2'b00);

        // Single result on channel 2.
        drive2(2, 64'hDEAD, 8'd5);
        bus2.fu_ex_i[2] = '{cause: 64'd2, tval: 64'd0, valid: 1'b1};
        tick();
        idle2();
        check("t1_valid",  bus2.wb_valid_o, 2'b01);
        check("t1_result", bus2.wb_result_o[0], 64'hDEAD);
        check("t1_tag",    bus2.wb_trans_id_o[0], 5);
        check("t1_src",    bus2.wb_src_o[0], 2);
        check("t1_exv",    bus2.wb_ex_o[0].valid, 1);
        check("t1_excause", bus2.wb_ex_o[0].cause, 2);
        check("t1_p1_zero", bus2.wb_result_o[1], 0);
        tick();
        check("t1_drain", bus2.wb_valid_o, 2'b00);

        // A flush returns the round-robin pointer to 0.
        bus2.flush_i = 1'b1;
        tick();
        bus2.flush_i = 1'b0;

        // Four-way collision.
        for (int i = 0; i < 4; i++) drive2(i, 64'h100 + 64'(i), 8'(i));
        tick();
        idle2();
        check("c4_a_valid", bus2.wb_valid_o, 2'b11);
        check("c4_a_src0",  bus2.wb_src_o[0], 0);
        check("c4_a_src1",  bus2.wb_src_o[1], 1);
        check("c4_a_tag0",  bus2.wb_trans_id_o[0], 0);
        check("c4_a_tag1",  bus2.wb_trans_id_o[1], 1);
        tick();
        check("c4_b_valid", bus2.wb_valid_o, 2'b11);
        check("c4_b_src0",  bus2.wb_src_o[0], 2);
        check("c4_b_src1",  bus2.wb_src_o[1], 3);
        check("c4_b_tag0",  bus2.wb_trans_id_o[0], 2);
        check("c4_b_tag1",  bus2.wb_trans_id_o[1], 3);
        check("c4_b_res0",  bus2.wb_result_o[0], 64'h102);
        tick();
        check("c4_c_valid", bus2.wb_valid_o, 2'b00);

        // Backpressure on channel 0 (rr = 0, all empty).
        drive2(0, 64'h200, 8'd30);
        tick();
        check("bp0_valid", bus2.wb_valid_o, 2'b01);
        check("bp0_tag0",  bus2.wb_trans_id_o[0], 30);
        drive2(0, 64'h201, 8'd31);
        drive2(1, 64'h300, 8'd40);
        drive2(2, 64'h301, 8'd41);
        tick();
        check("bp1_valid", bus2.wb_valid_o, 2'b11);
        check("bp1_src0",  bus2.wb_src_o[0], 1);
        check("bp1_src1",  bus2.wb_src_o[1], 2);
        check("bp1_tag0",  bus2.wb_trans_id_o[0], 40);
        check("bp1_tag1",  bus2.wb_trans_id_o[1], 41);
        check("bp1_ready0", bus2.fu_ready_o[0], 1);
        bus2.fu_valid_i[1] = 1'b0;
        bus2.fu_valid_i[2] = 1'b0;
        drive2(0, 64'h202, 8'd32);
        tick();
        check("bp2_ready",  bus2.fu_ready_o, 4'b1110);
        check("bp2_valid",  bus2.wb_valid_o, 2'b01);
        check("bp2_src0",   bus2.wb_src_o[0], 0);
        check("bp2_tag0",   bus2.wb_trans_id_o[0], 31);
        drive2(0, 64'h203, 8'd33);
        tick();
        check("bp3_ready0", bus2.fu_ready_o[0], 1);
        check("bp3_valid",  bus2.wb_valid_o, 2'b01);
        check("bp3_tag0",   bus2.wb_trans_id_o[0], 32);
        tick();
        idle2();
        check("bp4_valid",  bus2.wb_valid_o, 2'b01);
        check("bp4_tag0",   bus2.wb_trans_id_o[0], 33);
        check("bp4_res0",   bus2.wb_result_o[0], 64'h203);
        tick();
        check("bp5_valid",  bus2.wb_valid_o, 2'b00);

        // Alternation with one write port.
        bus1.fu_valid_i[0]    = 1'b1;
        bus1.fu_result_i[0]   = 64'h400;
        bus1.fu_trans_id_i[0] = 8'd0;
        bus1.fu_valid_i[1]    = 1'b1;
        bus1.fu_result_i[1]   = 64'h401;
        bus1.fu_trans_id_i[1] = 8'd1;
        for (int c = 0; c < 16; c++) begin
            tick();
            check("fair_valid", bus1.wb_valid_o, 1'b1);
            check("fair_src",   bus1.wb_src_o[0], 64'(c % 2));
        end
        idle1();

        // Flush while channels 0 and 1 are full (rr = 1, all empty).
        drive2(1, 64'h500, 8'd50);
        tick();
        idle2();
        check("fl_x_valid", bus2.wb_valid_o, 2'b01);
        check("fl_x_src0",  bus2.wb_src_o[0], 1);
        for (int i = 0; i < 4; i++) drive2(i, 64'h600 + 64'(i), 8'(60 + i));
        tick();
        idle2();
        check("fl_a_valid", bus2.wb_valid_o, 2'b11);
        check("fl_a_src0",  bus2.wb_src_o[0], 2);
        check("fl_a_src1",  bus2.wb_src_o[1], 3);
        check("fl_a_tag0",  bus2.wb_trans_id_o[0], 62);
        drive2(0, 64'h604, 8'd64);
        drive2(1, 64'h605, 8'd65);
        tick();
        idle2();
        check("fl_b_ready", bus2.fu_ready_o, 4'b1100);
        check("fl_b_valid", bus2.wb_valid_o, 2'b11);
        check("fl_b_tag0",  bus2.wb_trans_id_o[0], 60);
        check("fl_b_tag1",  bus2.wb_trans_id_o[1], 61);
        bus2.flush_i = 1'b1;
        drive2(3, 64'h700, 8'd70);
        tick();
        idle2();
        check("fl_c_valid", bus2.wb_valid_o, 2'b00);
        check("fl_c_ready", bus2.fu_ready_o, 4'hF);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("fl_after_valid", bus2.wb_valid_o, 2'b00);
        end

        // Asynchronous reset with buffered entries.
        drive2(0, 64'h800, 8'd80);
        drive2(1, 64'h801, 8'd81);
        drive2(2, 64'h802, 8'd82);
        tick();
        idle2();
        check("ar_pre_valid", bus2.wb_valid_o, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("ar_valid",  bus2.wb_valid_o, 2'b00);
        check("ar_ready",  bus2.fu_ready_o, 4'hF);
        check("ar_result", bus2.wb_result_o[0], 0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("ar_post_valid0", bus2.wb_valid_o, 2'b00);
        tick();
        check("ar_post_valid1", bus2.wb_valid_o, 2'b00);
        check("ar_post_dut1",   bus1.wb_valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Parametrised writeback merger between the execute-stage functional units and the scoreboard write ports.
- Generalises the single fixed-latency result mux to NrFu producer channels and NrWbPorts scoreboard write ports.
- Each channel has its own result FIFO, so a unit can hand off a result without waiting for a free write port.
- A round-robin arbiter grants up to NrWbPorts channels per cycle, so no unit starves and results are not dropped on collision.

Parameters:
- NrFu, 4, number of producer channels (2..8).
- NrWbPorts, 2, number of scoreboard write ports (1..NrFu).
- Depth, 2, FIFO entries per channel; power of two, at least 2.
- DataWidth, 64, result width.
- TransIdBits, ariane_pkg::TRANS_ID_BITS, scoreboard tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- flush_i  in  1  synchronous flush; drops all buffered results.
- fu_valid_i  in  NrFu  channel result valid.
- fu_ready_o  out  NrFu  channel can accept a result.
- fu_result_i  in  NrFu x DataWidth  result data.
- fu_trans_id_i  in  NrFu x TransIdBits  scoreboard tag.
- fu_ex_i  in  NrFu x exception_t  exception information.
- wb_valid_o  out  NrWbPorts  write-port valid.
- wb_result_o  out  NrWbPorts x DataWidth  written result.
- wb_trans_id_o  out  NrWbPorts x TransIdBits  written tag.
- wb_ex_o  out  NrWbPorts x exception_t  written exception.
- wb_src_o  out  NrWbPorts x clog2(NrFu)  granted channel index (debug and assertions).

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst_i high, asynchronous):
  - All FIFOs are empty; read and write pointers are 0; round-robin pointer rr_q is 0.
  - Outputs during and after reset: wb_valid_o=0, wb_result_o=0, wb_trans_id_o=0, wb_ex_o=0, wb_src_o=0, fu_ready_o all 1.
  - A reset in the middle of operation discards all buffered entries with no writeback.
- Enqueue:
  - A result is accepted when fu_valid_i[i] and fu_ready_o[i] are both high at a clock edge.
  - fu_ready_o[i] = !full[i], registered-state based. There is no same-cycle lookahead, so a full FIFO refuses a result even while it is being popped.
  - Producers must hold valid and payload until accepted.
- Occupancy and pointers:
  - Per-channel count is clog2(Depth)+1 bits.
  - Read and write pointers wrap modulo Depth.
  - full = (count==Depth); empty = (count==0).
  - A simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- Latency:
  - Minimum latency is 1 cycle: a result accepted at edge N appears on a write port in cycle N+1.
  - There is no combinational bypass from input to output.
- Arbitration (combinational on FIFO heads):
  - Candidates are channels with !empty.
  - Scan order is rr_q, rr_q+1, ..., wrapping modulo NrFu.
  - The first NrWbPorts candidates found are granted, in scan order, to wb ports 0, 1, ... .
  - Unused ports drive valid=0 and zero payload.
  - Write ports always accept, so every grant pops its FIFO at the next edge.
  - If at least one grant is made, rr_q updates to (index of last granted channel + 1) mod NrFu. If no grant is made, rr_q holds.
- Flush:
  - flush_i empties all FIFOs at the next edge.
  - An input presented in the same cycle as flush_i is dropped, even if handshaken.
  - rr_q is reset to 0.
  - wb_valid_o is still driven during the flush cycle; the scoreboard ignores it because it is being flushed too.
- Ordering:
  - Results from one channel are written in enqueue order.
  - No ordering is guaranteed across channels.
- Assertions (simulation only):
  - No two write ports carry the same wb_src_o in a cycle.
  - No two write ports carry the same wb_trans_id_o in a cycle.
  - No push to a full FIFO.

Decomposition:
- ariane_pkg: exception_t and TRANS_ID_BITS, both existing; new typedef wb_entry_t = {result, trans_id, ex}.
- Sub-module wb_fifo: single-channel FIFO parametrised by Depth and entry type; outputs full, empty, and the head entry. Instantiated NrFu times.
- The top level holds the round-robin scan and rr_q register.

Test Plan:
- Reset and single result: reset, then drive channel 2 with result=0xDEAD, tag=5 for one cycle. Required: the next cycle shows wb_valid_o=01, wb_result_o[0]=0xDEAD, wb_trans_id_o[0]=5, wb_src_o[0]=2; the following cycle shows wb_valid_o=00.
- Four-way collision: all 4 channels push tags 0..3 in one cycle with rr_q=0. Required: cycle +1 writes channels {0,1} on ports {0,1} and rr_q becomes 2; cycle +2 writes channels {2,3}; cycle +3 shows valid=00.
- Backpressure: channel 0 pushes on 3 consecutive cycles while channels 1..3 are kept busy so channel 0 is not granted. Required: fu_ready_o[0] drops to 0 after 2 accepts; the third push is held until the FIFO pops; tags are written in push order.
- Fairness: channels 0 and 1 stream continuously with NrWbPorts=1. Required: grants strictly alternate 0, 1, 0, 1 over 16 cycles.
- Flush mid-stream: both FIFOs of channels 0 and 1 are full and flush_i is asserted together with a push on channel 3. Required: next cycle wb_valid_o=00, all fu_ready_o=1, and the channel 3 result never appears.
- Async reset mid-operation: assert rst_i between clock edges while FIFOs are non-empty. Required: wb_valid_o goes to 0 immediately, and no stale result appears after release.
